fifo_wr_arb: RTL
================

# fifo_wr_arb

Packet-granular round-robin write arbiter that shares one 64-bit × 512-deep scfifo-based buffer (almost-full threshold 400) among several upstream requesters. Each requester presents valid/ready/last beats. The arbiter grants one requester for a whole packet, throttles on the buffer's almost-full and full flags, and drives the buffer write port through one register stage. It sits between the per-source packet builders and the shared buffer, on the buffer's write side.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 64: data width; matches the buffer width.
- `MAX_BEATS`, default 256: longest legal packet; forces the grant to release.

Ports:
- `clk`  in  1  the single clock.
- `srst`  in  1  reset. Synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester beat valid.
- `req_last`  in  N_REQ  per-requester end-of-packet, qualified by valid.
- `req_data`  in  N_REQ*W  per-requester data; requester i occupies bits [i*W +: W].
- `req_ready`  out  N_REQ  per-requester accept.
- `fifo_full`  in  1  buffer full.
- `fifo_afull`  in  1  buffer almost-full (prog_full).
- `fifo_wr_en`  out  1  buffer write strobe.
- `fifo_din`  out  W  buffer write data.
- `grant_id`  out  clog2(N_REQ)  current or most recent grantee.
- `busy`  out  1  a grant is held.
- `pkt_done`  out  1  one-cycle pulse, coincident with the final write of a packet.
- `trunc_err`  out  1  one-cycle pulse, coincident with `pkt_done`, when the packet was cut at `MAX_BEATS`.

## Operation
- The FSM has two states: IDLE and GRANT.
- IDLE:
  - `req_ready` = 0.
  - If any `req_valid` is set, select the first set bit searching from `rr_ptr`, wrapping modulo N_REQ.
  - Load `grant_id`, clear `beat_cnt`, go to GRANT.
- GRANT:
  - `space` = ~fifo_afull & ~fifo_full.
  - `req_ready[grant_id]` = `space`; all other ready bits are 0.
  - Accept = `req_valid[grant_id]` & `space`. Each accept increments `beat_cnt`, which is clog2(MAX_BEATS)+1 bits wide.
  - Release when an accepted beat has `req_last`=1, or when `beat_cnt` == MAX_BEATS-1 at accept. The latter is truncation: the beat is written, then the grant drops.
  - On release: `rr_ptr` ← (grant_id+1) mod N_REQ, go to IDLE.
- A valid deasserting mid-packet does not release the grant. The arbiter waits.
- Requesters that are not granted see ready=0 and must hold their data.
- Output stage, registered:
  - `fifo_wr_en` ← accept.
  - `fifo_din` ← granted data.
  - `pkt_done` ← accept & release.
  - `trunc_err` ← accept & release due to truncation & ~req_last.
- Reset values:
  - state = IDLE, `rr_ptr` = 0, `grant_id` = 0, `beat_cnt` = 0.
  - `busy`, `fifo_wr_en`, `pkt_done`, `trunc_err` = 0.
  - `fifo_din` = 0.
  - All `req_ready` = 0.

## Timing
- Arbitration: a valid seen in IDLE at cycle t gives grant and `busy`=1 at t+1. Ready can rise at t+1.
- Accept at cycle t gives `fifo_wr_en` at t+1 (one-cycle write latency).
- Back-to-back packets have exactly one IDLE bubble between the last beat of one packet and the first possible accept of the next.
- Throughput inside a packet is one beat per cycle while `space`=1.
- Afull margin: because of the register stage, at most 1 beat is written after `fifo_afull` is seen, so occupancy never exceeds threshold+1. `fifo_full` is never written into.
- `srst` mid-packet: the grant is abandoned, the in-flight registered write is dropped (`fifo_wr_en`=0 the next cycle), and `rr_ptr` returns to 0. The partial packet in the buffer is the system's responsibility. The buffer shares the same `srst`.
- Simultaneous requests in IDLE: the lowest index at or after `rr_ptr`, cyclically, wins.

## Structure
- Shared package `fifo_arb_pkg`: `W` default, `N_REQ` default, index-width function clog2, state enum {IDLE, GRANT}.
- One natural sub-module: `rr_pick`, a combinational rotate-priority encoder with inputs (req vector, ptr) and outputs (idx, any).
- Everything else (FSM, beat counter, output register) stays in `fifo_wr_arb`.

## Test plan
- Single packet: req0 sends 3 beats 0xA0..0xA2 with last on the third, buffer empty.
  - Required: grant at t+1, `fifo_wr_en` high for 3 consecutive cycles starting t+2.
  - `pkt_done` high with the 0xA2 write; `rr_ptr`=1.
- Round-robin fairness: all 4 requesters continuously send 2-beat packets.
  - Required: grant order 0,1,2,3,0; each packet is contiguous; one bubble between packets.
- Backpressure: assert `fifo_afull` during beat 2 of a 5-beat packet.
  - Required: `req_ready` drops the same cycle; no accept while asserted.
  - On deassert the packet resumes with no lost or duplicated beats; the sequence checked at the buffer is intact.
- Truncation: MAX_BEATS=8, req2 streams 10 beats with no last.
  - Required: 8 writes, `pkt_done`=`trunc_err`=1 on the 8th, grant released.
  - The remaining 2 beats are delivered as a new packet once req2 is next granted.
- Mid-packet reset: pulse `srst` after 2 of 4 beats.
  - Required: `fifo_wr_en`=0 the next cycle, `busy`=0, all ready 0, `rr_ptr`=0.
  - A request from req0 is granted at the first IDLE after reset.
- Valid gap: the granted requester drops valid for 3 cycles mid-packet.
  - Required: the grant is held, other requesters stay ready=0, `beat_cnt` is unchanged during the gap.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the packet-granular write arbiter in front of the shared buffer.
package fifo_arb_pkg;

  localparam int W_DEFAULT         = 64;
  localparam int N_REQ_DEFAULT     = 4;
  localparam int MAX_BEATS_DEFAULT = 256;

  // Bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEFAULT,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan offsets from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin, packet-granular write arbiter feeding one shared buffer through a
// single register stage; throttles on almost-full/full and cuts packets at MAX_BEATS.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int W         = W_DEFAULT,
  parameter int MAX_BEATS = MAX_BEATS_DEFAULT,
  localparam int IW       = clog2(N_REQ),
  localparam int CW       = clog2(MAX_BEATS) + 1
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               fifo_full,
  input  logic               fifo_afull,
  output logic               fifo_wr_en,
  output logic [W-1:0]       fifo_din,
  output logic [IW-1:0]      grant_id,
  output logic               busy,
  output logic               pkt_done,
  output logic               trunc_err
);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [W-1:0]  din_q, din_d;
  logic          pkt_done_q, pkt_done_d;
  logic          trunc_err_q, trunc_err_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          space;
  logic          accept;
  logic          release_now;
  logic          last_beat;
  logic          trunc_hit;
  logic [IW-1:0] next_ptr;
  logic [W-1:0]  gnt_data;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The register stage adds one beat of latency, so afull leaves room for it.
  assign space     = ~fifo_afull & ~fifo_full;
  assign gnt_data  = req_data[int'(grant_id_q) * W +: W];
  assign last_beat = req_last[grant_id_q];
  assign trunc_hit = (beat_cnt_q == CW'(MAX_BEATS - 1));
  assign next_ptr  = (grant_id_q == IW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    req_ready   = '0;
    accept      = 1'b0;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id_q] = space;
        accept = req_valid[grant_id_q] & space;
        if (accept) begin
          beat_cnt_d  = beat_cnt_q + 1'b1;
          release_now = last_beat | trunc_hit;
          if (release_now) begin
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d     = accept;
    din_d       = accept ? gnt_data : din_q;
    pkt_done_d  = accept & release_now;
    trunc_err_d = accept & trunc_hit & ~last_beat;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      beat_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      din_q       <= '0;
      pkt_done_q  <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
      pkt_done_q  <= pkt_done_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == GRANT);
  assign pkt_done   = pkt_done_q;
  assign trunc_err  = trunc_err_q;

endmodule
